// File: rtl/nyancat_anim_ctrl.sv
// rtl/nyancat_anim_ctrl.sv - vsync-aligned animation frame sequencer for the nyancat renderer
// Frame index only moves on frame_start, so the renderer never sees a mid-frame change.
module nyancat_anim_ctrl #(
  parameter int NUM_FRAMES   = 12,
  parameter int RATE_W       = 8,
  parameter int DEFAULT_RATE = 6,
  parameter int AUTOPLAY     = 1
) (
  input  logic                          px_clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [RATE_W-1:0]             cmd_data,
  output logic [$clog2(NUM_FRAMES)-1:0] frame_index,
  output logic                          frame_advance,
  output logic                          playing
);

  localparam int IDX_W = $clog2(NUM_FRAMES);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_FRAMES - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [RATE_W-1:0] RATE_ONE  = RATE_W'(1);
  localparam logic [RATE_W-1:0] RATE_INIT = RATE_W'(DEFAULT_RATE);

  localparam logic [1:0] OP_PLAY     = 2'd0;
  localparam logic [1:0] OP_PAUSE    = 2'd1;
  localparam logic [1:0] OP_STEP     = 2'd2;
  localparam logic [1:0] OP_SET_RATE = 2'd3;

  typedef enum logic [1:0] {
    PLAYING   = 2'd0,
    PAUSED    = 2'd1,
    STEP_WAIT = 2'd2
  } state_t;

  localparam state_t RESET_STATE = (AUTOPLAY != 0) ? PLAYING : PAUSED;

  state_t            state_q, state_d;
  logic [RATE_W-1:0] tick_q, tick_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              adv_q, adv_d;
  logic [RATE_W-1:0] tick_last;
  logic [IDX_W-1:0]  idx_next;
  logic              accept;

  // A stored rate of zero behaves as one: advance on every frame_start.
  assign tick_last = (rate_q == '0) ? '0 : rate_q - RATE_ONE;
  assign idx_next  = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_ONE;

  assign cmd_ready     = (state_q != STEP_WAIT);
  assign accept        = cmd_valid && cmd_ready;
  assign playing       = (state_q == PLAYING);
  assign frame_index   = idx_q;
  assign frame_advance = adv_q;

  always_ff @(posedge px_clk) begin
    if (reset) begin
      state_q <= RESET_STATE;
      tick_q  <= '0;
      rate_q  <= RATE_INIT;
      idx_q   <= '0;
      adv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      rate_q  <= rate_d;
      idx_q   <= idx_d;
      adv_q   <= adv_d;
    end
  end

  // frame_start is resolved against the old state first; a command accepted in
  // the same cycle is layered on top, so a SET_RATE clear beats an increment.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    rate_d  = rate_q;
    idx_d   = idx_q;
    adv_d   = 1'b0;

    case (state_q)
      PLAYING: begin
        if (frame_start) begin
          if (tick_q == tick_last) begin
            tick_d = '0;
            idx_d  = idx_next;
            adv_d  = 1'b1;
          end else begin
            tick_d = tick_q + RATE_ONE;
          end
        end
      end
      STEP_WAIT: begin
        if (frame_start) begin
          idx_d   = idx_next;
          adv_d   = 1'b1;
          state_d = PAUSED;
        end
      end
      default: ;
    endcase

    if (accept) begin
      case (cmd_op)
        OP_PLAY:  state_d = PLAYING;
        OP_PAUSE: state_d = PAUSED;
        OP_STEP: begin
          if (state_q == PAUSED) state_d = STEP_WAIT;
        end
        OP_SET_RATE: begin
          rate_d = cmd_data;
          tick_d = '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nyancat_anim_ctrl.sv
// tb/tb_nyancat_anim_ctrl.sv - directed self-checking bench for nyancat_anim_ctrl
module tb_nyancat_anim_ctrl;

  logic       px_clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_data = 8'd0;
  logic       cmd_ready, frame_advance, playing;
  logic [3:0] frame_index;

  logic       cmd_valid_b = 1'b0;
  logic       cmd_ready_b, frame_advance_b, playing_b;
  logic [3:0] frame_index_b;

  int n_tests = 0;
  int n_fail  = 0;
  int adv_cnt = 0;
  int adv_cnt_b = 0;
  int base;

  always #5 px_clk = ~px_clk;

  nyancat_anim_ctrl #(.NUM_FRAMES(12), .RATE_W(8), .DEFAULT_RATE(6), .AUTOPLAY(1)) dut (
    .px_clk(px_clk), .reset(reset), .frame_start(frame_start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .frame_index(frame_index), .frame_advance(frame_advance), .playing(playing)
  );

  nyancat_anim_ctrl #(.NUM_FRAMES(12), .RATE_W(8), .DEFAULT_RATE(6), .AUTOPLAY(0)) dut_paused (
    .px_clk(px_clk), .reset(reset), .frame_start(frame_start),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .frame_index(frame_index_b), .frame_advance(frame_advance_b), .playing(playing_b)
  );

  always @(negedge px_clk) begin
    if (frame_advance === 1'b1) adv_cnt <= adv_cnt + 1;
    if (frame_advance_b === 1'b1) adv_cnt_b <= adv_cnt_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] data, input logic with_fs);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_data    = data;
    frame_start = with_fs;
    tick();
    cmd_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  initial begin
    idle(2);
    reset = 1'b0;

    check("rst_idx", frame_index, 0);
    check("rst_adv", frame_advance, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_playing", playing, 1);
    check("rst_rate", dut.rate_q, 6);
    check("rst_b_playing", playing_b, 0);
    check("rst_b_ready", cmd_ready_b, 1);

    // Default rate 6: one advance per six pulses, full wrap after 72.
    for (int k = 1; k <= 72; k++) begin
      pulse();
      check($sformatf("run_idx_%0d", k), frame_index, (k / 6) % 12);
      check($sformatf("run_adv_%0d", k), frame_advance, (k % 6 == 0) ? 1 : 0);
      if (k == 10) check("b_idx_10", frame_index_b, 0);
      idle(99);
    end
    check("run_adv_total", adv_cnt, 12);
    check("b_idx_final", frame_index_b, 0);
    check("b_adv_total", adv_cnt_b, 0);
    check("b_playing", playing_b, 0);

    // Pause with tick_cnt = 3, then resume and finish the held count.
    for (int k = 0; k < 3; k++) begin
      pulse();
      check("pre_pause_adv", frame_advance, 0);
      idle(3);
    end
    check("pause_ready", cmd_ready, 1);
    send_cmd(2'd1, 8'd0, 1'b0);
    check("paused_playing", playing, 0);
    base = adv_cnt;
    for (int k = 0; k < 20; k++) begin
      pulse();
      idle(3);
    end
    check("paused_idx", frame_index, 0);
    check("paused_adv_cnt", adv_cnt, base);
    send_cmd(2'd0, 8'd0, 1'b0);
    check("resume_playing", playing, 1);
    pulse(); check("resume_p1", frame_advance, 0); idle(2);
    pulse(); check("resume_p2", frame_advance, 0); idle(2);
    pulse(); check("resume_p3_adv", frame_advance, 1);
    check("resume_p3_idx", frame_index, 1);
    idle(2);

    // Rate 0 means every pulse advances; walk up to frame 11 and pause there.
    send_cmd(2'd3, 8'd0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      pulse();
      check($sformatf("r0_adv_%0d", k), frame_advance, 1);
      idle(2);
    end
    check("r0_idx", frame_index, 11);
    send_cmd(2'd1, 8'd0, 1'b0);

    // STEP with a simultaneous frame_start: that pulse must not count.
    send_cmd(2'd2, 8'd0, 1'b1);
    check("step_ready", cmd_ready, 0);
    check("step_idx_hold", frame_index, 11);
    check("step_adv_none", frame_advance, 0);
    idle(3);
    pulse();
    check("step_idx_wrap", frame_index, 0);
    check("step_adv", frame_advance, 1);
    check("step_ready_back", cmd_ready, 1);
    check("step_playing", playing, 0);
    tick();
    check("step_adv_single", frame_advance, 0);

    // Rate 0, then SET_RATE 2 together with an advancing pulse.
    send_cmd(2'd0, 8'd0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      pulse();
      check($sformatf("r0b_idx_%0d", k), frame_index, k);
      idle(2);
    end
    send_cmd(2'd3, 8'd2, 1'b1);
    check("sr_adv", frame_advance, 1);
    check("sr_idx", frame_index, 4);
    check("sr_tick", dut.tick_q, 0);
    check("sr_rate", dut.rate_q, 2);
    idle(2);
    pulse(); check("sr_p1", frame_advance, 0); idle(2);
    pulse(); check("sr_p2_adv", frame_advance, 1);
    check("sr_p2_idx", frame_index, 5);
    idle(2);

    // Reset while a step is pending.
    send_cmd(2'd1, 8'd0, 1'b0);
    send_cmd(2'd2, 8'd0, 1'b0);
    check("sw_ready", cmd_ready, 0);
    check("sw_idx", frame_index, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("sw_rst_idx", frame_index, 0);
    check("sw_rst_rate", dut.rate_q, 6);
    check("sw_rst_ready", cmd_ready, 1);
    check("sw_rst_playing", playing, 1);
    check("sw_rst_tick", dut.tick_q, 0);
    check("sw_rst_b_playing", playing_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
